// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit adder is reused over WIDTH/4 cycles, and the carry is
// registered between nibbles. Operands arrive and the result leaves over valid/ready handshakes.

module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign sum   = total[3:0];
  assign cout  = total[4];

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             busy
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] nib_idx;
  logic             carry_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic [3:0]       add_sum;
  logic             add_cout;

  adder_4bit u_adder (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)            state_nxt = RUN;
      RUN:  if (nib_idx == LAST_IDX) state_nxt = DONE;
      DONE: if (out_ready)           state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Datapath: operands shift down so the adder always sees the active nibble in bits [3:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      nib_idx <= '0;
      carry_q <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= op_a;
            b_sh    <= op_b;
            carry_q <= cin_in;
            nib_idx <= '0;
            sum_q   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (nib_idx == IDX_W'(i)) begin
              sum_q[4*i +: 4] <= add_sum;
            end
          end
          carry_q <= add_cout;
          a_sh    <= a_sh >> 4;
          b_sh    <= b_sh >> 4;
          if (nib_idx == LAST_IDX) begin
            cout_q  <= add_cout;
            nib_idx <= '0;
          end else begin
            nib_idx <= nib_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = !rst && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum_out   = sum_q;
  assign cout_out  = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (WIDTH=16): table vectors, backpressure, reset abort and
// back-to-back traffic, with a scoreboard filled on accept and drained on result handshake.

module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;
  logic             busy;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin_in    (cin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .cout_out  (cout_out),
    .busy      (busy)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t        vecs[6];
  logic [16:0] sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          prev_acc = 0;
  bit          have_prev = 1'b0;
  bit          spacing_chk = 1'b0;
  bit          acc_flag = 1'b0;
  bit          ov_prev = 1'b0;
  logic [15:0] last_sum = '0;
  logic        last_cout = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sample on the falling edge, then return just after the next rising edge so the
  // caller can drive inputs without racing the DUT.
  task automatic tick();
    @(negedge clk);
    cyc++;
    acc_flag = 1'b0;
    if (in_valid && in_ready) begin
      acc_flag = 1'b1;
      sb.push_back({1'b0, op_a} + {1'b0, op_b} + {16'h0000, cin_in});
      if (spacing_chk && have_prev) chk("accept_spacing", 32'(cyc - prev_acc), 32'(NIB + 2));
      prev_acc  = cyc;
      have_prev = 1'b1;
      acc_cyc   = cyc;
    end
    if (out_valid && !ov_prev) chk("latency", 32'(cyc - acc_cyc), 32'(NIB + 1));
    ov_prev = out_valid;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h/%b with empty scoreboard", sum_out, cout_out);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        chk("sb_sum", 32'(sum_out), 32'(e[15:0]));
        chk("sb_cout", 32'(cout_out), 32'(e[16]));
        last_sum  = sum_out;
        last_cout = cout_out;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
    int n;
    op_a     = a;
    op_b     = b;
    cin_in   = c;
    in_valid = 1'b1;
    n = 0;
    tick();
    while (!acc_flag && n < 100) begin
      tick();
      n++;
    end
    if (!acc_flag) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_a      = '0;
    op_b      = '0;
    cin_in    = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum_out), 32'd0);
    chk("rst_cout", 32'(cout_out), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_drain();
      chk("vec_sum", 32'(last_sum), 32'(vecs[i].sum));
      chk("vec_cout", 32'(last_cout), 32'(vecs[i].cout));
    end

    // Backpressure: result must freeze and new operands must be refused.
    out_ready = 1'b0;
    send(16'h4321, 16'h1111, 1'b1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
    end
    chk("hold_reached", 32'(out_valid), 32'd1);
    for (int k = 0; k < 6; k++) begin
      op_a     = 16'($urandom);
      op_b     = 16'($urandom);
      cin_in   = 1'($urandom);
      in_valid = 1'b1;
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(sum_out), 32'h5433);
      chk("hold_cout", 32'(cout_out), 32'd0);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_sb", 32'(sb.size()), 32'd0);

    // Reset asserted across the second RUN cycle aborts the operation.
    send(16'h8888, 16'h8888, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum_out), 32'd0);
    chk("abort_cout", 32'(cout_out), 32'd0);
    chk("abort_in_ready_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    sb.delete();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_no_pulse", 32'(out_valid), 32'd0);
    end
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    send(16'h0001, 16'h0001, 1'b0);
    wait_drain();
    chk("post_abort_sum", 32'(last_sum), 32'h0002);
    chk("post_abort_cout", 32'(last_cout), 32'd0);

    // Back-to-back random operations with the consumer always ready.
    spacing_chk = 1'b1;
    have_prev   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom));
    end
    wait_drain();
    spacing_chk = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
